// File: rtl/fcw_sequencer.sv
// fcw_sequencer: walks four frequency control words held in an external RAM,
// presenting each to the NCO for a programmable number of clk cycles.
module fcw_sequencer #(
  parameter int               DUR_W       = 26,
  parameter logic [DUR_W-1:0] NOTE_CYCLES = 26'd62_500_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             play,
  input  logic             next,
  input  logic             dur_wr_en,
  input  logic [DUR_W-1:0] dur_in,
  output logic [1:0]       ram_addr,
  output logic             ram_rd_en,
  input  logic [23:0]      ram_d_out,
  output logic [23:0]      fcw,
  output logic             fcw_valid,
  output logic [1:0]       note_idx,
  output logic             note_start
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LATCH = 2'd2,
    PLAY  = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [1:0]       idx_r, idx_s;
  logic [23:0]      fcw_r, fcw_s;
  logic             valid_r, valid_s;
  logic             start_r, start_s;
  logic [DUR_W-1:0] cnt_r, cnt_s;
  logic [DUR_W-1:0] dur_r;

  // A zero duration would underflow the counter, so it is stored as one cycle.
  function automatic logic [DUR_W-1:0] clamp_dur(input logic [DUR_W-1:0] d);
    if (d == {DUR_W{1'b0}}) begin
      clamp_dur = DUR_W'(1'b1);
    end else begin
      clamp_dur = d;
    end
  endfunction

  // Next-state and next-value logic; play low always wins over everything else.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    fcw_s   = fcw_r;
    valid_s = valid_r;
    start_s = 1'b0;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (play) begin
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (!play) begin
          state_s = IDLE;
          valid_s = 1'b0;
        end else begin
          state_s = LATCH;
        end
      end
      LATCH: begin
        if (!play) begin
          state_s = IDLE;
          valid_s = 1'b0;
        end else begin
          state_s = PLAY;
          fcw_s   = ram_d_out;
          valid_s = 1'b1;
          start_s = 1'b1;
          cnt_s   = dur_r - DUR_W'(1'b1);
        end
      end
      PLAY: begin
        if (!play) begin
          state_s = IDLE;
          valid_s = 1'b0;
        end else if ((cnt_r == {DUR_W{1'b0}}) || next) begin
          state_s = FETCH;
          idx_s   = idx_r + 2'd1;
        end else begin
          cnt_s   = cnt_r - DUR_W'(1'b1);
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
      end
    endcase
  end

  // Sequencer state and the values presented to the NCO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      idx_r   <= 2'd0;
      fcw_r   <= 24'd0;
      valid_r <= 1'b0;
      start_r <= 1'b0;
      cnt_r   <= {DUR_W{1'b0}};
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      fcw_r   <= fcw_s;
      valid_r <= valid_s;
      start_r <= start_s;
      cnt_r   <= cnt_s;
    end
  end

  // Duration register; a new value is only picked up by the next LATCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dur_r <= NOTE_CYCLES;
    end else if (dur_wr_en) begin
      dur_r <= clamp_dur(dur_in);
    end else begin
      dur_r <= dur_r;
    end
  end

  assign ram_rd_en  = (state_r == FETCH);
  assign ram_addr   = idx_r;
  assign note_idx   = idx_r;
  assign fcw        = fcw_r;
  assign fcw_valid  = valid_r;
  assign note_start = start_r;

endmodule

// File: doc/fcw_sequencer.md
FCW_SEQUENCER -- requirements
Module: fcw_sequencer

Interface
REQ-001 SHALL have parameter NOTE_CYCLES, default 26'd62_500_000, the reset note duration in clk cycles.
REQ-002 SHALL have parameter DUR_W, default 26, the width of the duration register and counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low (rst=0 resets).
REQ-005 SHALL have port play  input  1  level; 1 = sequence notes, 0 = pause.
REQ-006 SHALL have port next  input  1  single-cycle pulse; skip to the following note.
REQ-007 SHALL have port dur_wr_en  input  1  write enable for the duration register.
REQ-008 SHALL have port dur_in  input  DUR_W  new note duration in cycles.
REQ-009 SHALL have port ram_addr  output  2  FCW RAM address; always equals note_idx.
REQ-010 SHALL have port ram_rd_en  output  1  FCW RAM read enable.
REQ-011 SHALL have port ram_d_out  input  24  FCW RAM read data; valid the cycle after ram_rd_en.
REQ-012 SHALL have port fcw  output  24  frequency control word to the NCO.
REQ-013 SHALL have port fcw_valid  output  1  fcw holds a fetched word.
REQ-014 SHALL have port note_idx  output  2  index of the current note.
REQ-015 SHALL have port note_start  output  1  one-cycle pulse on the cycle fcw takes a new value.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, LATCH and PLAY, with state, fcw, fcw_valid, note_start and the counter all registered.
REQ-017 IDLE: SHALL go to FETCH when play=1, and otherwise stay in IDLE.
REQ-018 FETCH: SHALL drive ram_rd_en=1 (decoded from state) with ram_addr=note_idx, then go to LATCH.
REQ-019 LATCH: on the clock edge leaving LATCH, SHALL set fcw<=ram_d_out, fcw_valid<=1, note_start<=1, cnt<=dur-1, and go to PLAY.
REQ-020 PLAY: SHALL decrement cnt each cycle; when cnt=0 or next=1, SHALL set note_idx<=note_idx+1 (mod 4, so 3 wraps to 0) and go to FETCH.
REQ-021 ram_rd_en SHALL be 0 in every state except FETCH.
REQ-022 Note period SHALL be exactly dur+2 cycles between consecutive note_start pulses when next is not asserted.
REQ-023 fcw and fcw_valid SHALL hold their values through FETCH and LATCH of subsequent notes, so the NCO sees no gap.
REQ-024 play=0 in any non-IDLE state SHALL force IDLE at the next edge; fcw_valid<=0, fcw holds, note_idx is unchanged.
REQ-025 Resume after a pause SHALL refetch the same note_idx, with the counter restarted at full duration.
REQ-026 play=0 and next=1 in the same cycle: play wins; note_idx SHALL NOT change.
REQ-027 next=1 together with cnt=0 SHALL advance note_idx by exactly one.
REQ-028 next SHALL be ignored in IDLE, FETCH and LATCH.
REQ-029 dur_wr_en=1 SHALL update the duration register the next cycle, taking effect at the next LATCH; the note in progress keeps its count.
REQ-030 dur_in=0 SHALL be stored as 1.
REQ-031 note_start SHALL be 0 on every cycle other than the one following LATCH.

Reset
REQ-032 rst=0 SHALL immediately force state=IDLE, note_idx=0, fcw=0, fcw_valid=0, note_start=0, cnt=0, dur=NOTE_CYCLES, ram_rd_en=0, regardless of clk.
REQ-033 Reset asserted mid-PLAY SHALL abandon the note, with no further ram_rd_en until play is seen high after release.
REQ-034 After release, the first FETCH SHALL occur one cycle after play is sampled high.

Verification
REQ-035 Bench SHALL cover: NOTE_CYCLES=4, RAM {60508, 67934, 71922, 80723}, play held 1 -> note_start every 6 cycles; fcw sequence 60508, 67934, 71922, 80723, 60508 (wrap); first fcw_valid 3 cycles after play rises.
REQ-036 Bench SHALL cover: next pulsed on the 2nd PLAY cycle of note 0 -> fcw=67934 appears 3 cycles later; idx=1.
REQ-037 Bench SHALL cover: play dropped during note 2 for 10 cycles, then raised -> fcw_valid low while paused, fcw stays 71922; 71922 is refetched with a full 4-cycle duration.
REQ-038 Bench SHALL cover: dur_in=0 written, then dur_in=1 written -> note_start spacing becomes 3 cycles from the next note; next together with cnt=0 advances idx by one only.
REQ-039 Bench SHALL cover: rst pulsed low between clock edges during PLAY -> all outputs reach reset values before the next edge; ram_rd_en stays 0 until play is seen high after release.
REQ-040 Bench SHALL check throughout: ram_rd_en is high only in FETCH; ram_addr equals note_idx on every cycle.
